// File: rtl/mix_backward_logic_if.sv
// Bundles the run/result signals and the weight-read and weight-gradient-write ports of the mix backward block.
// The master side is the backward engine; the slave side is the controller and weight memory.
interface mix_backward_logic_if #(
    parameter int DATA_N  = 6,
    parameter int IN_DIM  = 24,
    parameter int HID_DIM = 24,
    parameter int N_LEN   = 16,
    parameter int N_LEN_W = 8,
    parameter int ADDR_W  = 7
);
    logic                         run;
    logic                         valid;
    logic [HID_DIM*N_LEN-1:0]     dy;
    logic [IN_DIM*N_LEN-1:0]      x;
    logic [IN_DIM*N_LEN-1:0]      dx;
    logic [ADDR_W-1:0]            raddr_w;
    logic [DATA_N*N_LEN_W-1:0]    rdata_w;
    logic                         wen_dw;
    logic [ADDR_W-1:0]            waddr_dw;
    logic [DATA_N*N_LEN-1:0]      wdata_dw;

    modport master (
        input  run, dy, x, rdata_w,
        output valid, dx, raddr_w, wen_dw, waddr_dw, wdata_dw
    );

    modport slave (
        output run, dy, x, rdata_w,
        input  valid, dx, raddr_w, wen_dw, waddr_dw, wdata_dw
    );
endinterface

// File: rtl/mix_backward_logic.sv
// Mix-layer backward pass: streams one weight word per cycle, accumulates dx = W^T*dy and writes dW = dy*x^T.
// dW write for word a lands in cycle a+2, valid rises in cycle TOTAL+2; no backpressure, run low aborts and clears.
module mix_backward_logic #(
    parameter int DATA_N  = 6,
    parameter int IN_DIM  = 24,
    parameter int HID_DIM = 24,
    parameter int N_LEN   = 16,
    parameter int F_LEN_D = 8,
    parameter int N_LEN_W = 8,
    parameter int F_LEN   = 6,
    parameter int ADDR_W  = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mix_backward_logic_if.master bus
);
    localparam int CH    = IN_DIM / DATA_N;
    localparam int TOTAL = HID_DIM * CH;
    localparam int CW    = $clog2(TOTAL + 3);
    localparam int JW    = $clog2(HID_DIM + 1);
    localparam int KW    = (CH > 1) ? $clog2(CH) : 1;
    localparam int PW    = N_LEN + F_LEN;
    localparam int GW    = N_LEN + F_LEN_D;

    // Word counter and the (row j, chunk k) of the word being addressed
    logic [CW-1:0]     r_c;
    logic [JW-1:0]     r_j;
    logic [KW-1:0]     r_k;

    logic              r_s1_vld;
    logic [ADDR_W-1:0] r_s1_addr;
    logic [JW-1:0]     r_s1_j;
    logic [KW-1:0]     r_s1_k;

    logic              r_s2_vld;
    logic [ADDR_W-1:0] r_s2_addr;
    logic [KW-1:0]     r_s2_k;
    logic [N_LEN-1:0]  r_p [DATA_N];
    logic [N_LEN-1:0]  r_g [DATA_N];

    logic [N_LEN-1:0]  r_acc [CH][DATA_N];

    logic                     w_issue;
    logic [N_LEN-1:0]         w_dy_arr [HID_DIM];
    logic [N_LEN-1:0]         w_x_arr [CH][DATA_N];
    logic signed [N_LEN-1:0]  w_dy;
    logic signed [PW-1:0]     w_dy_p;
    logic signed [GW-1:0]     w_dy_g;
    logic [N_LEN-1:0]         w_p [DATA_N];
    logic [N_LEN-1:0]         w_g [DATA_N];
    logic [DATA_N*N_LEN-1:0]  w_wdata;
    logic [IN_DIM*N_LEN-1:0]  w_dx;

    assign w_issue = (r_c < CW'(TOTAL));

    for (genvar j = 0; j < HID_DIM; j++) begin : g_dy
        assign w_dy_arr[j] = bus.dy[j*N_LEN +: N_LEN];
    end

    for (genvar k = 0; k < CH; k++) begin : g_xk
        for (genvar m = 0; m < DATA_N; m++) begin : g_xm
            assign w_x_arr[k][m] = bus.x[(k*DATA_N+m)*N_LEN +: N_LEN];
        end
    end

    assign w_dy   = $signed(w_dy_arr[r_s1_j]);
    assign w_dy_p = PW'(w_dy);
    assign w_dy_g = GW'(w_dy);

    // Products are formed only as wide as the kept bits need; the high bits would be discarded anyway
    for (genvar m = 0; m < DATA_N; m++) begin : g_lane
        logic signed [PW-1:0] w_wt;
        logic signed [PW-1:0] w_pw;
        logic signed [GW-1:0] w_xv;
        logic signed [GW-1:0] w_gx;
        assign w_wt   = PW'($signed(bus.rdata_w[m*N_LEN_W +: N_LEN_W]));
        assign w_xv   = GW'($signed(w_x_arr[r_s1_k][m]));
        assign w_pw   = w_dy_p * w_wt;
        assign w_gx   = w_dy_g * w_xv;
        assign w_p[m] = N_LEN'(w_pw >>> F_LEN);
        assign w_g[m] = N_LEN'(w_gx >>> F_LEN_D);
    end

    always_comb begin
        w_wdata = '0;
        for (int m = 0; m < DATA_N; m++) begin
            w_wdata[m*N_LEN +: N_LEN] = r_g[m];
        end
    end

    always_comb begin
        w_dx = '0;
        for (int k = 0; k < CH; k++) begin
            for (int m = 0; m < DATA_N; m++) begin
                w_dx[(k*DATA_N+m)*N_LEN +: N_LEN] = r_acc[k][m];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c       <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_addr <= '0;
            r_s1_j    <= '0;
            r_s1_k    <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_addr <= '0;
            r_s2_k    <= '0;
            for (int m = 0; m < DATA_N; m++) begin
                r_p[m] <= '0;
                r_g[m] <= '0;
            end
            for (int k = 0; k < CH; k++) begin
                for (int m = 0; m < DATA_N; m++) begin
                    r_acc[k][m] <= '0;
                end
            end
        end else if (!bus.run) begin
            // Abort: in-flight writes are dropped and the next run starts from scratch
            r_c       <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_addr <= '0;
            r_s1_j    <= '0;
            r_s1_k    <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_addr <= '0;
            r_s2_k    <= '0;
            for (int m = 0; m < DATA_N; m++) begin
                r_p[m] <= '0;
                r_g[m] <= '0;
            end
            for (int k = 0; k < CH; k++) begin
                for (int m = 0; m < DATA_N; m++) begin
                    r_acc[k][m] <= '0;
                end
            end
        end else begin
            if (r_c != CW'(TOTAL + 2)) begin
                r_c <= r_c + 1'b1;
            end
            if (w_issue) begin
                if (r_k == KW'(CH - 1)) begin
                    r_k <= '0;
                    r_j <= r_j + 1'b1;
                end else begin
                    r_k <= r_k + 1'b1;
                end
                r_s1_addr <= ADDR_W'(r_c);
                r_s1_j    <= r_j;
                r_s1_k    <= r_k;
            end
            r_s1_vld <= w_issue;

            r_s2_vld  <= r_s1_vld;
            r_s2_addr <= r_s1_addr;
            r_s2_k    <= r_s1_k;
            for (int m = 0; m < DATA_N; m++) begin
                r_p[m] <= w_p[m];
                r_g[m] <= w_g[m];
            end

            if (r_s2_vld) begin
                for (int m = 0; m < DATA_N; m++) begin
                    r_acc[r_s2_k][m] <= r_acc[r_s2_k][m] + r_p[m];
                end
            end
        end
    end

    assign bus.raddr_w  = w_issue ? ADDR_W'(r_c) : ADDR_W'(TOTAL - 1);
    assign bus.wen_dw   = r_s2_vld;
    assign bus.waddr_dw = r_s2_addr;
    assign bus.wdata_dw = w_wdata;
    assign bus.dx       = w_dx;
    assign bus.valid    = bus.run && (r_c == CW'(TOTAL + 2));

endmodule

// File: doc/mix_backward_logic.md
MIX_BACKWARD_LOGIC -- requirements
Module: mix_backward_logic

Interface
REQ-001 Parameter DATA_N, 6, weight/data elements per weight word.
REQ-002 Parameter IN_DIM, 24, mix-layer input length (multiple of DATA_N).
REQ-003 Parameter HID_DIM, 24, mix-layer output length.
REQ-004 Parameter N_LEN, 16, data width; F_LEN_D, 8, data fraction bits.
REQ-005 Parameter N_LEN_W, 8, weight width; F_LEN, 6, weight fraction bits.
REQ-006 Parameter ADDR_W, 7, weight/gradient word address width.
REQ-007 clk  input  1  clock.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 run  input  1  level enable; low clears and aborts.
REQ-010 valid  output  1  dx complete.
REQ-011 dy  input  HID_DIM*N_LEN  upstream gradient; element j at [j*N_LEN +: N_LEN]; stable while run.
REQ-012 x  input  IN_DIM*N_LEN  saved forward input; element i at [i*N_LEN +: N_LEN]; stable while run.
REQ-013 raddr_w  output  ADDR_W  weight word address.
REQ-014 rdata_w  input  DATA_N*N_LEN_W  weight word, one-cycle read latency.
REQ-015 wen_dw, waddr_dw, wdata_dw  output  1, ADDR_W, DATA_N*N_LEN  weight-gradient write port.
REQ-016 dx  output  IN_DIM*N_LEN  input gradient, element i at [i*N_LEN +: N_LEN].

Function
REQ-017 Define CH = IN_DIM/DATA_N, TOTAL = HID_DIM*CH (96); word a = j*CH+k holds W[j][k*DATA_N+m] at lane m.
REQ-018 Cycle counter c starts 0 in first run-high cycle, increments each run cycle, saturates at TOTAL+2.
REQ-019 raddr_w = c while c < TOTAL, else holds TOTAL-1.
REQ-020 Stage 1: capture rdata_w with delayed (j,k) of the address issued previous cycle.
REQ-021 Stage 2 (registered): p_m = signed dy[j] * signed W lane m, keep bits [F_LEN +: N_LEN]; g_m = signed dy[j] * signed x[k*DATA_N+m], keep bits [F_LEN_D +: N_LEN].
REQ-022 Stage 3: acc[k*DATA_N+m] += p_m, N_LEN-bit two's-complement wrap, no saturation.
REQ-023 wen_dw high exactly one cycle per word a, in cycle a+2; waddr_dw = a; wdata_dw lane m = g_m.
REQ-024 dx = acc registers directly.
REQ-025 valid = run & (c == TOTAL+2); first high in cycle TOTAL+2 (98), holds while run.
REQ-026 Sequence: no backpressure; throughput one weight word per cycle; 96 consecutive writes addresses 0..95.
REQ-027 run low (any cycle, including mid-sequence): next edge clears c, pipeline, acc; wen_dw, waddr_dw, wdata_dw, dx, valid, raddr_w all 0.
REQ-028 run re-asserted after low: restarts from c=0; result independent of aborted run.
REQ-029 Writes in flight at abort are dropped, not completed.

Reset
REQ-030 rst_n low: all registers 0 immediately; valid 0, raddr_w 0, wen_dw 0, waddr_dw 0, wdata_dw 0, dx 0.
REQ-031 rst_n mid-run then released with run high: behaves as fresh run starting c=0.

Verification
REQ-032 All weights 0x40 (1.0), all dy 0x0100 (1.0), run held -> valid rises cycle 98; every dx = 0x1800 (24.0).
REQ-033 dy[3]=0x0200, other dy 0, row-3 weights 0xE0 (-0.5), others 0x7F -> every dx = 0xFF00 (-1.0).
REQ-034 All dy 0x0100, all x 0x0080 -> wen_dw high cycles 2..97, waddr_dw 0..95 consecutive, every lane 0x0080.
REQ-035 All dy 0x4000, weights 0x40 -> every dx = 0x0000 (1536.0 wraps); valid still cycle 98.
REQ-036 Drop run at cycle 50 -> cycle 51: wen_dw 0, dx 0, valid 0; rerun yields REQ-032 results.
REQ-037 Pulse rst_n low at cycle 40 -> outputs 0 immediately; after release, full 96-write sequence and valid at cycle 98 relative to release.
